// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Bridges a processor data port (ReadData/WriteData with a wait request) to
//   a simple memory port (MemReq held until a one-cycle MemAck). Each access
//   runs IDLE -> REQ -> DONE. A timeout aborts a REQ that never gets MemAck,
//   returns 0xDEAD to the processor and raises a sticky BusError.
//
//   Optional feature macro: DATA_MEM_CTRL_WRITE_BUFFER_EN
//     Adds a one-entry posted write buffer. A write arriving in IDLE is
//     accepted with no wait and drains through REQ in the background.
//
// Ports
//   Clock, Resetn            rising-edge clock, async active-low reset
//   DataAddr, DataOut        processor address / store data
//   ReadData, WriteData      processor load / store request
//   DataIn                   load data returned to the processor
//   DataWaitreq              processor must hold its request while high
//   MemReq, MemWe            memory request and direction (1 = write)
//   MemAddr, MemWData        memory address / write data
//   MemRData, MemAck         memory read data, valid with the MemAck pulse
//   BusError                 sticky timeout flag
//   dbg_state_o              current FSM state (0 IDLE, 1 REQ, 2 DONE)
//
// Handshake: the processor raises ReadData or WriteData with address/data
// stable and keeps all of them stable while DataWaitreq is high; the access
// has completed in the first cycle the request is high and DataWaitreq is
// low. On the memory side MemReq/MemWe/MemAddr/MemWData stay constant until
// the cycle in which MemAck is high; MemAck outside MemReq is ignored.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 MemReq,
  output logic                 MemWe,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWData,
  input  logic [WORD_SIZE-1:0] MemRData,
  input  logic                 MemAck,
  output logic                 BusError,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter value seen in the last REQ cycle that may still take MemAck.
  localparam logic [7:0]           TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [WORD_SIZE-1:0] ERR_WORD  = WORD_SIZE'(16'hDEAD);

  state_e                 state_q, state_d;
  logic [WORD_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]   data_in_q, data_in_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   wait_c;
  logic                   posted;   // current REQ is a background buffer drain

`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
  logic posted_q, posted_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) posted_q <= 1'b0;
    else         posted_q <= posted_d;
  end
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_in_q <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_in_q <= data_in_d;
      we_q      <= we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_in_d = data_in_q;
    we_d      = we_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wait_c    = 1'b0;
    posted    = 1'b0;
`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
    posted_d  = posted_q;
    posted    = posted_q;
`endif
    unique case (state_q)
      IDLE: begin
        wait_c = ReadData | WriteData;
        if (ReadData | WriteData) begin
          state_d = REQ;
          addr_d  = DataAddr;
          wdata_d = DataOut;
          we_d    = WriteData;   // read+write together is a write
          cnt_d   = '0;
`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
          // Writes are posted: accepted now, completed in the background.
          posted_d = WriteData;
          wait_c   = ~WriteData;
`endif
        end
      end
      REQ: begin
        // While draining a posted write the processor is not waiting on us,
        // but any new request must stall until the buffer is empty.
        wait_c = posted ? (ReadData | WriteData) : 1'b1;
        if (MemAck) begin
          if (!we_q) data_in_d = MemRData;
          state_d = posted ? IDLE : DONE;
`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
          posted_d = 1'b0;
`endif
        end else if (cnt_q == TO_LAST) begin
          err_d = 1'b1;
          if (!posted) data_in_d = ERR_WORD;
          state_d = posted ? IDLE : DONE;
`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
          posted_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        wait_c  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MemReq      = (state_q == REQ);
  // Gated by Resetn so the wait request drops the moment reset is asserted.
  assign DataWaitreq = Resetn & wait_c;
  assign MemWe       = we_q;
  assign MemAddr     = addr_q;
  assign MemWData    = wdata_q;
  assign DataIn      = data_in_q;
  assign BusError    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed table of processor accesses with hand-computed expectations,
//   plus hand-written sequences for reset, stray MemAck, reset mid-access and
//   (when DATA_MEM_CTRL_WRITE_BUFFER_EN is defined) a posted write followed
//   by a read.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int W  = 16;
  localparam int TO = 4;

`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Resetn;
  logic [W-1:0] DataAddr, DataOut, DataIn, MemAddr, MemWData, MemRData;
  logic         ReadData, WriteData, DataWaitreq, MemReq, MemWe, MemAck, BusError;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           n_req;    // REQ cycles, MemAck in the last; 0 = never ack
    logic [W-1:0] rdata;
    logic [W-1:0] exp_din;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  data_mem_ctrl #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData),
    .DataIn(DataIn), .DataWaitreq(DataWaitreq),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .BusError(BusError),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard compare ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver: one processor access ----------------
  task automatic do_txn(input vec_t v, input string nm);
    logic posted, timeout;
    int   n;
    posted  = WB && v.wr;
    timeout = (v.n_req == 0);
    n       = timeout ? TO : v.n_req;
    exp_q.push_back(v.exp_din);

    @(posedge Clock); #1;
    ReadData = v.rd; WriteData = v.wr; DataAddr = v.addr; DataOut = v.wdata;
    MemAck = 1'b0; MemRData = 16'hFFFF;
    @(negedge Clock);
    check({nm, " c0 waitreq"}, DataWaitreq, !posted);
    check({nm, " c0 memreq"},  MemReq, 1'b0);

    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      if (posted) begin ReadData = 1'b0; WriteData = 1'b0; end
      MemAck   = !timeout && (i == n - 1);
      MemRData = MemAck ? v.rdata : 16'hFFFF;
      @(negedge Clock);
      check($sformatf("%s req%0d memreq", nm, i),  MemReq, 1'b1);
      check($sformatf("%s req%0d memwe", nm, i),   MemWe, v.wr);
      check($sformatf("%s req%0d memaddr", nm, i), MemAddr, v.addr);
      check($sformatf("%s req%0d wdata", nm, i),   MemWData, v.wdata);
      check($sformatf("%s req%0d waitreq", nm, i), DataWaitreq, !posted);
    end

    @(posedge Clock); #1;
    MemAck = 1'b0; MemRData = 16'hFFFF;
    @(negedge Clock);
    check({nm, " done memreq"},  MemReq, 1'b0);
    check({nm, " done waitreq"}, DataWaitreq, 1'b0);
    check({nm, " done state"},   dbg_state, posted ? 2'd0 : 2'd2);
    check({nm, " done buserr"},  BusError, v.exp_err);
    check({nm, " done datain"},  DataIn, exp_q.pop_front());

    @(posedge Clock); #1;
    ReadData = 1'b0; WriteData = 1'b0;
    @(negedge Clock);
    check({nm, " after state"},  dbg_state, 2'd0);
    check({nm, " after wait"},   DataWaitreq, 1'b0);
    check({nm, " after datain"}, DataIn, v.exp_din);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 3, 16'h0000, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 2, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'h0200, 16'h5555, 1, 16'h9999, 16'hA5A5, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 4, 16'h0F0F, 16'h0F0F, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 0, 16'h0000, 16'hDEAD, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 16'h0500, 16'h1111, 1, 16'h0000, 16'hDEAD, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h0600, 16'h0000, 1, 16'h7777, 16'h7777, 1'b1};

    // Reset with a request already present: everything must read zero.
    Resetn = 1'b0; ReadData = 1'b1; WriteData = 1'b0;
    DataAddr = 16'h0123; DataOut = 16'h4567; MemAck = 1'b0; MemRData = '0;
    repeat (2) @(negedge Clock);
    check("rst waitreq", DataWaitreq, 1'b0);
    check("rst memreq",  MemReq, 1'b0);
    check("rst memwe",   MemWe, 1'b0);
    check("rst buserr",  BusError, 1'b0);
    check("rst datain",  DataIn, 16'h0000);
    check("rst memaddr", MemAddr, 16'h0000);
    check("rst wdata",   MemWData, 16'h0000);
    check("rst state",   dbg_state, 2'd0);
    ReadData = 1'b0;
    @(posedge Clock); #1; Resetn = 1'b1;

    // Idle with no request, and a stray MemAck that must be ignored.
    @(negedge Clock);
    check("idle waitreq", DataWaitreq, 1'b0);
    @(posedge Clock); #1; MemAck = 1'b1; MemRData = 16'hABCD;
    @(posedge Clock); #1; MemAck = 1'b0;
    @(negedge Clock);
    check("stray ack datain", DataIn, 16'h0000);
    check("stray ack memreq", MemReq, 1'b0);
    check("stray ack state",  dbg_state, 2'd0);

    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of REQ: drops immediately, access abandoned.
    @(posedge Clock); #1;
    ReadData = 1'b1; DataAddr = 16'h0700; DataOut = 16'h0000;
    repeat (2) @(posedge Clock);
    #1;
    @(negedge Clock);
    check("midreq memreq before", MemReq, 1'b1);
    #2; Resetn = 1'b0;
    #1;
    check("midreq memreq",  MemReq, 1'b0);
    check("midreq waitreq", DataWaitreq, 1'b0);
    check("midreq buserr",  BusError, 1'b0);
    check("midreq datain",  DataIn, 16'h0000);
    check("midreq state",   dbg_state, 2'd0);
    ReadData = 1'b0;
    @(posedge Clock); #1; Resetn = 1'b1;
    v = '{1'b1, 1'b0, 16'h0800, 16'h0000, 1, 16'h2468, 16'h2468, 1'b0};
    do_txn(v, "post_rst");

`ifdef DATA_MEM_CTRL_WRITE_BUFFER_EN
    // Posted write immediately followed by a read.
    @(posedge Clock); #1;
    WriteData = 1'b1; DataAddr = 16'h0900; DataOut = 16'hC0DE;
    @(negedge Clock);
    check("wb write wait", DataWaitreq, 1'b0);
    @(posedge Clock); #1;
    WriteData = 1'b0; ReadData = 1'b1; DataAddr = 16'h0A00;
    @(negedge Clock);
    check("wb drain memreq", MemReq, 1'b1);
    check("wb drain memwe",  MemWe, 1'b1);
    check("wb drain addr",   MemAddr, 16'h0900);
    check("wb drain wdata",  MemWData, 16'hC0DE);
    check("wb read wait0",   DataWaitreq, 1'b1);
    @(posedge Clock); #1; MemAck = 1'b1;
    @(negedge Clock);
    check("wb read wait1", DataWaitreq, 1'b1);
    @(posedge Clock); #1; MemAck = 1'b0;
    @(negedge Clock);
    check("wb idle wait",   DataWaitreq, 1'b1);
    check("wb idle memreq", MemReq, 1'b0);
    @(posedge Clock); #1; MemAck = 1'b1; MemRData = 16'h3C3C;
    @(negedge Clock);
    check("wb rd memreq", MemReq, 1'b1);
    check("wb rd memwe",  MemWe, 1'b0);
    check("wb rd addr",   MemAddr, 16'h0A00);
    check("wb rd wait",   DataWaitreq, 1'b1);
    @(posedge Clock); #1; MemAck = 1'b0;
    @(negedge Clock);
    check("wb rd done wait", DataWaitreq, 1'b0);
    check("wb rd datain",    DataIn, 16'h3C3C);
    @(posedge Clock); #1; ReadData = 1'b0;
`endif

    repeat (2) @(posedge Clock);
    check("scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
